softreg_responder: RTL and testbench
====================================

SOFTREG_RESPONDER -- requirements
Module: softreg_responder

Interface
REQ-001 Parameter DATA_W, default 64, SoftReg data and parameter register width.
REQ-002 Parameter ADDR_W, default 32, SoftReg address width.
REQ-003 clk  in  1  sole clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 softreg_req_valid  in  1  one-cycle request strobe from host.
REQ-006 softreg_req_isWrite  in  1  1 = write, 0 = read.
REQ-007 softreg_req_addr  in  ADDR_W  register address.
REQ-008 softreg_req_data  in  DATA_W  write data.
REQ-009 softreg_resp_valid  out  1  one-cycle read-response strobe.
REQ-010 softreg_resp_data  out  DATA_W  read-response data.
REQ-011 n_vert, n_inedges, vaddr, ieaddr, write_addr0, write_addr1, n_rounds  out  DATA_W each  parameter registers to the core.
REQ-012 start  out  1  one-cycle start pulse to the core.
REQ-013 busy  out  1  high from start pulse until done_i is seen.
REQ-014 done_i  in  1  core completion level; result_i valid while high.
REQ-015 result_i  in  DATA_W  final result (total sum).

Function
REQ-016 Address map SHALL be: 0 N_VERT, 1 N_INEDGES, 2 VADDR, 3 IEADDR, 4 WRITE_ADDR0, 5 WRITE_ADDR1, 6 N_ROUNDS, 7 DONE_READ_PARAMS, 8 DONE_ALL; other addresses decode as unmapped.
REQ-017 FSM states SHALL be CONFIG, RUN, DONE; reset state CONFIG.
REQ-018 In CONFIG, a valid write to addresses 0-6 SHALL update that register on the next edge; the register output is visible one cycle after the request.
REQ-019 A valid write to address 7 in CONFIG SHALL pulse start for exactly one cycle (the cycle after the request), assert busy, and move to RUN; write data is ignored.
REQ-020 In RUN and DONE, writes to addresses 0-7 SHALL be ignored; registers and state are unchanged.
REQ-021 RUN SHALL go to DONE on the first cycle done_i is sampled high; busy deasserts on the same edge, and result_i is latched into an internal result register.
REQ-022 A valid read of address 8 in DONE SHALL produce softreg_resp_valid=1 with the latched result exactly one cycle after the request.
REQ-023 A valid read of address 8 in CONFIG or RUN SHALL be held pending, with no response.
REQ-024 A pending read SHALL be answered one cycle after the DONE transition with the latched result.
REQ-025 While a read is pending, further read requests SHALL be dropped without response; only one response is produced.
REQ-026 A write to address 8 in DONE SHALL return the FSM to CONFIG (rearm), keeping all parameter values; in other states it is ignored.
REQ-027 Every accepted read SHALL produce exactly one response; at most one response per cycle; softreg_resp_data SHALL be 0 whenever softreg_resp_valid is 0.
REQ-028 Reads of unmapped addresses SHALL respond one cycle later with data 0.
REQ-029 done_i high in CONFIG SHALL be ignored.

Reset
REQ-030 On rst, all parameter registers, the result register, softreg_resp_valid, softreg_resp_data, start and busy SHALL be 0, the FSM SHALL be CONFIG, and any pending read SHALL be discarded without response.
REQ-031 A request in the same cycle as rst SHALL be ignored; reset mid-RUN SHALL not produce start or a response.

Configuration
REQ-032 With SOFTREG_READBACK_EN defined, reads of addresses 0-6 SHALL respond one cycle later with the stored value, and a read of address 7 SHALL return {busy, FSM state} zero-extended.
REQ-033 Without SOFTREG_READBACK_EN, reads of addresses 0-7 SHALL respond one cycle later with data 0.

Verification
REQ-034 After reset, write N_VERT=10, N_INEDGES=56, IEADDR=160, N_ROUNDS=4, then write addr 7 -> outputs hold those values, start is high for exactly 1 cycle, busy=1.
REQ-035 Read addr 8 while in RUN; done_i rises 50 cycles later with result_i=0x1234 -> exactly one response, 1 cycle after DONE, with data 0x1234.
REQ-036 In RUN, write N_VERT=99 -> n_vert stays 10; after DONE, read addr 8 -> response 1 cycle later with the latched value even though result_i has since changed.
REQ-037 Assert rst while a read is pending -> no response ever, all outputs 0, FSM CONFIG; a new start sequence then works.
REQ-038 Read addr 0 after writing 10 -> data 10 with SOFTREG_READBACK_EN, data 0 without; read addr 15 -> data 0 in both builds.

Source files
------------

// File: rtl/softreg_responder.sv
// SoftReg host responder: parameter registers, start/busy handshake to the core, result readback.
// Build option SOFTREG_READBACK_EN: addresses 0-7 read back stored values/status instead of 0.
module softreg_responder #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              softreg_req_valid,
  input  logic              softreg_req_isWrite,
  input  logic [ADDR_W-1:0] softreg_req_addr,
  input  logic [DATA_W-1:0] softreg_req_data,
  output logic              softreg_resp_valid,
  output logic [DATA_W-1:0] softreg_resp_data,
  output logic [DATA_W-1:0] n_vert,
  output logic [DATA_W-1:0] n_inedges,
  output logic [DATA_W-1:0] vaddr,
  output logic [DATA_W-1:0] ieaddr,
  output logic [DATA_W-1:0] write_addr0,
  output logic [DATA_W-1:0] write_addr1,
  output logic [DATA_W-1:0] n_rounds,
  output logic              start,
  output logic              busy,
  input  logic              done_i,
  input  logic [DATA_W-1:0] result_i,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_RUN    = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_pending;
  logic [DATA_W-1:0] r_result;

  logic              w_wr;
  logic              w_rd;
  logic              w_addr_done;
  logic [2:0]        w_status;
  logic [DATA_W-1:0] w_rd_data;

  // Handshake: a request is a single-cycle strobe on softreg_req_valid (no ready);
  // each accepted read yields one single-cycle softreg_resp_valid, data forced to 0 otherwise.
  assign w_wr        = softreg_req_valid & softreg_req_isWrite;
  assign w_rd        = softreg_req_valid & ~softreg_req_isWrite;
  assign w_addr_done = (softreg_req_addr == ADDR_W'(8));
  assign w_status    = {busy, r_state};
  assign o_dbg_state = r_state;

  always_comb begin
    w_rd_data = '0;
`ifdef SOFTREG_READBACK_EN
    case (softreg_req_addr)
      ADDR_W'(0): w_rd_data = n_vert;
      ADDR_W'(1): w_rd_data = n_inedges;
      ADDR_W'(2): w_rd_data = vaddr;
      ADDR_W'(3): w_rd_data = ieaddr;
      ADDR_W'(4): w_rd_data = write_addr0;
      ADDR_W'(5): w_rd_data = write_addr1;
      ADDR_W'(6): w_rd_data = n_rounds;
      ADDR_W'(7): w_rd_data = DATA_W'(w_status);
      default:    w_rd_data = '0;
    endcase
`else
    w_rd_data = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_CONFIG;
      r_pending          <= 1'b0;
      r_result           <= '0;
      n_vert             <= '0;
      n_inedges          <= '0;
      vaddr              <= '0;
      ieaddr             <= '0;
      write_addr0        <= '0;
      write_addr1        <= '0;
      n_rounds           <= '0;
      start              <= 1'b0;
      busy               <= 1'b0;
      softreg_resp_valid <= 1'b0;
      softreg_resp_data  <= '0;
    end else begin
      start              <= 1'b0;
      softreg_resp_valid <= 1'b0;
      softreg_resp_data  <= '0;

      case (r_state)
        ST_CONFIG: begin
          if (w_wr) begin
            case (softreg_req_addr)
              ADDR_W'(0): n_vert      <= softreg_req_data;
              ADDR_W'(1): n_inedges   <= softreg_req_data;
              ADDR_W'(2): vaddr       <= softreg_req_data;
              ADDR_W'(3): ieaddr      <= softreg_req_data;
              ADDR_W'(4): write_addr0 <= softreg_req_data;
              ADDR_W'(5): write_addr1 <= softreg_req_data;
              ADDR_W'(6): n_rounds    <= softreg_req_data;
              ADDR_W'(7): begin
                start   <= 1'b1;
                busy    <= 1'b1;
                r_state <= ST_RUN;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (done_i) begin
            r_state  <= ST_DONE;
            busy     <= 1'b0;
            r_result <= result_i;
          end
        end
        ST_DONE: begin
          if (w_wr && w_addr_done) r_state <= ST_CONFIG;
        end
        default: r_state <= ST_CONFIG;
      endcase

      // A pending read is always served on the first DONE cycle, so it never competes
      // with a fresh read; reads arriving while one is pending are dropped.
      if (r_pending && (r_state == ST_DONE)) begin
        softreg_resp_valid <= 1'b1;
        softreg_resp_data  <= r_result;
        r_pending          <= 1'b0;
      end else if (w_rd && !r_pending) begin
        if (w_addr_done) begin
          if (r_state == ST_DONE) begin
            softreg_resp_valid <= 1'b1;
            softreg_resp_data  <= r_result;
          end else begin
            r_pending <= 1'b1;
          end
        end else begin
          softreg_resp_valid <= 1'b1;
          softreg_resp_data  <= w_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_softreg_responder.sv
// Bench for softreg_responder: vector table for CONFIG accesses, hand sequences for run/done/reset,
// response scoreboard with expected data and arrival cycle.
module tb_softreg_responder;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
`ifdef SOFTREG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              softreg_req_valid = 1'b0;
  logic              softreg_req_isWrite = 1'b0;
  logic [ADDR_W-1:0] softreg_req_addr = '0;
  logic [DATA_W-1:0] softreg_req_data = '0;
  logic              softreg_resp_valid;
  logic [DATA_W-1:0] softreg_resp_data;
  logic [DATA_W-1:0] n_vert, n_inedges, vaddr, ieaddr, write_addr0, write_addr1, n_rounds;
  logic              start, busy;
  logic              done_i = 1'b0;
  logic [DATA_W-1:0] result_i = '0;
  logic [1:0]        o_dbg_state;

  softreg_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
    .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
    .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data),
    .n_vert(n_vert), .n_inedges(n_inedges), .vaddr(vaddr), .ieaddr(ieaddr),
    .write_addr0(write_addr0), .write_addr1(write_addr1), .n_rounds(n_rounds),
    .start(start), .busy(busy), .done_i(done_i), .result_i(result_i),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int                exp_t_q[$];
  bit                mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (softreg_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          chk("resp_data", softreg_resp_data, exp_q.pop_front());
          chk("resp_cycle", DATA_W'(cyc), DATA_W'(exp_t_q.pop_front()));
        end
      end else begin
        chk("resp_valid_known", DATA_W'(softreg_resp_valid), 0);
        chk("idle_data_zero", softreg_resp_data, 0);
        if (exp_t_q.size() > 0 && exp_t_q[0] < cyc) begin
          chk("missing_resp", 0, 1);
          void'(exp_q.pop_front());
          void'(exp_t_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    softreg_req_valid   = 1'b1;
    softreg_req_isWrite = wr;
    softreg_req_addr    = addr;
    softreg_req_data    = data;
    tick();
    softreg_req_valid   = 1'b0;
    softreg_req_isWrite = 1'b0;
    softreg_req_data    = DATA_W'($urandom_range(0, 65535));
  endtask

  task automatic read_exp(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    exp_q.push_back(exp);
    exp_t_q.push_back(cyc + 1);
    req(1'b0, addr, '0);
  endtask

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
  } vec_t;
  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 32'd0,  64'd10,  64'd0};
    vecs[1]  = '{1'b1, 32'd1,  64'd56,  64'd0};
    vecs[2]  = '{1'b1, 32'd3,  64'd160, 64'd0};
    vecs[3]  = '{1'b1, 32'd6,  64'd4,   64'd0};
    vecs[4]  = '{1'b0, 32'd0,  64'd0,   RB ? 64'd10 : 64'd0};
    vecs[5]  = '{1'b0, 32'd1,  64'd0,   RB ? 64'd56 : 64'd0};
    vecs[6]  = '{1'b0, 32'd2,  64'd0,   64'd0};
    vecs[7]  = '{1'b0, 32'd3,  64'd0,   RB ? 64'd160 : 64'd0};
    vecs[8]  = '{1'b0, 32'd6,  64'd0,   RB ? 64'd4 : 64'd0};
    vecs[9]  = '{1'b0, 32'd7,  64'd0,   64'd0};
    vecs[10] = '{1'b0, 32'd15, 64'd0,   64'd0};
    vecs[11] = '{1'b0, 32'd9,  64'd0,   64'd0};

    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_n_vert", n_vert, 0);
    chk("rst_n_rounds", n_rounds, 0);
    chk("rst_start", DATA_W'(start), 0);
    chk("rst_busy", DATA_W'(busy), 0);
    chk("rst_state", DATA_W'(o_dbg_state), 0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) req(1'b1, vecs[i].addr, vecs[i].data);
      else read_exp(vecs[i].addr, vecs[i].exp);
    end
    chk("n_vert", n_vert, 10);
    chk("n_inedges", n_inedges, 56);
    chk("vaddr", vaddr, 0);
    chk("ieaddr", ieaddr, 160);
    chk("write_addr0", write_addr0, 0);
    chk("write_addr1", write_addr1, 0);
    chk("n_rounds", n_rounds, 4);

    // start pulse, then pending read and ignored writes in RUN
    req(1'b1, 32'd7, 64'hDEAD);
    chk("start_pulse", DATA_W'(start), 1);
    chk("busy_on", DATA_W'(busy), 1);
    req(1'b0, 32'd8, '0);
    chk("start_one_cycle", DATA_W'(start), 0);
    chk("state_run", DATA_W'(o_dbg_state), 1);
    req(1'b1, 32'd0, 64'd99);
    chk("n_vert_locked", n_vert, 10);
    req(1'b0, 32'd8, '0);
    req(1'b1, 32'd7, '0);
    chk("no_restart", DATA_W'(start), 0);
    repeat (45) tick();
    chk("busy_run", DATA_W'(busy), 1);

    done_i = 1'b1;
    result_i = 64'h1234;
    exp_q.push_back(64'h1234);
    exp_t_q.push_back(cyc + 2);
    tick();
    chk("state_done", DATA_W'(o_dbg_state), 2);
    chk("busy_off", DATA_W'(busy), 0);
    done_i = 1'b0;
    result_i = 64'h5555;
    repeat (3) tick();
    read_exp(32'd8, 64'h1234);
    read_exp(32'd7, RB ? 64'd2 : 64'd0);
    req(1'b1, 32'd0, 64'd77);
    chk("n_vert_done_locked", n_vert, 10);

    // rearm keeps parameters; done_i in CONFIG ignored
    req(1'b1, 32'd8, '0);
    chk("rearm_state", DATA_W'(o_dbg_state), 0);
    chk("rearm_keeps", n_inedges, 56);
    done_i = 1'b1;
    repeat (3) tick();
    chk("done_in_config", DATA_W'(o_dbg_state), 0);
    done_i = 1'b0;

    // reset with pending read, request during reset
    req(1'b1, 32'd7, '0);
    req(1'b0, 32'd8, '0);
    rst = 1'b1;
    req(1'b1, 32'd7, '0);
    chk("rst_req_ignored", DATA_W'(start), 0);
    tick();
    rst = 1'b0;
    done_i = 1'b1;
    result_i = 64'hBEEF;
    chk("rst2_busy", DATA_W'(busy), 0);
    chk("rst2_state", DATA_W'(o_dbg_state), 0);
    chk("rst2_n_vert", n_vert, 0);
    repeat (4) tick();
    done_i = 1'b0;

    // new run after reset
    req(1'b1, 32'd0, 64'd5);
    req(1'b1, 32'd7, '0);
    chk("restart_pulse", DATA_W'(start), 1);
    chk("restart_n_vert", n_vert, 5);
    repeat (3) tick();
    done_i = 1'b1;
    result_i = 64'hABCD;
    tick();
    done_i = 1'b0;
    result_i = 64'h0;
    read_exp(32'd8, 64'hABCD);
    repeat (5) tick();
    chk("sb_drained", DATA_W'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1);
  end
endmodule
